// File: rtl/dmem_wait_ctrl.sv
// Data memory for the MEM stage with req/ready/done handshake, programmable
// wait states, byte-enable writes, registered read data and an error response.
module dmem_wait_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic                ready_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = $clog2(BE_W);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              misaligned, out_of_range;
    logic              mem_wr, mem_rd, rd_clr;

    assign misaligned   = |addr_i[OFF_W-1:0];
    assign out_of_range = 32'(addr_i[ADDR_W-1:OFF_W]) >= DEPTH;

    assign ready_o = (state_q == S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        mem_wr  = 1'b0;
        mem_rd  = 1'b0;
        rd_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    idx_d   = MEM_AW'(addr_i[ADDR_W-1:OFF_W]);
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    if (misaligned || out_of_range) begin
                        // Error completes next cycle; a failed read also clears rdata.
                        err_d   = 1'b1;
                        rd_clr  = !we_i;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_wr  = we_q && rst_ni;
                    mem_rd  = !we_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // One byte-wide RAM per lane keeps byte-enable writes inferable as block RAM.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk_i) begin
            if (mem_wr && be_q[gi]) begin
                mem_q[idx_q] <= wdata_q[8*gi +: 8];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rd_byte_q <= '0;
            end else if (mem_rd) begin
                rd_byte_q <= mem_q[idx_q];
            end else if (rd_clr) begin
                rd_byte_q <= '0;
            end
        end

        assign rdata_o[8*gi +: 8] = rd_byte_q;
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: three instances cover W=2/DEPTH=200,
// W=3 (reset abort) and W=0 (back-to-back throughput).
module tb_dmem_wait_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  req;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  ready, done, err;
    logic [31:0] rdata [3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(200), .WAIT_CYCLES(2)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[0]), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(ready[0]), .done_o(done[0]),
        .err_o(err[0]), .rdata_o(rdata[0]));

    dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_CYCLES(3)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[1]), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(ready[1]), .done_o(done[1]),
        .err_o(err[1]), .rdata_o(rdata[1]));

    dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[2]), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(ready[2]), .done_o(done[2]),
        .err_o(err[2]), .rdata_o(rdata[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one access; lat is the cycle offset of done relative to the accept cycle.
    task automatic access(input int k, input logic w, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int lat, output logic e, output logic [31:0] rd);
        int t = 0;
        while (!ready[k] && t < 50) begin
            step();
            t++;
        end
        check("ready_wait", 32'(ready[k]), 32'd1);
        we = w; addr = a; wdata = d; be = b; req[k] = 1'b1;
        step();
        req[k] = 1'b0;
        we = ~w; addr = ~a; wdata = ~d; be = ~b;
        lat = 1;
        while (!done[k] && lat < 50) begin
            step();
            lat++;
        end
        e  = err[k];
        rd = rdata[k];
        $display("inst%0d %s @%h wdata=%h be=%h -> lat=%0d err=%0b rdata=%h",
                 k, w ? "WR" : "RD", a, d, b, lat, e, rd);
        step();
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;
        int          dn, acc, run, run_min, run_max;

        rst_ni = 1'b0; req = 3'b111; we = 1'b1; addr = 10'h10; wdata = 32'hFFFF_FFFF; be = 4'hF;
        repeat (3) step();
        check("rst_ready", 32'(ready), 32'h7);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata_a", rdata[0], 32'h0);
        check("rst_rdata_c", rdata[2], 32'h0);
        req = 3'b000; rst_ni = 1'b1;
        step();

        access(0, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, lat, e, rd);
        check("w2_wr_lat", 32'(lat), 32'd4);
        check("w2_wr_err", 32'(e), 32'd0);
        access(0, 1'b0, 10'h010, 32'h0, 4'h0, lat, e, rd);
        check("w2_rd_lat", 32'(lat), 32'd4);
        check("w2_rd_err", 32'(e), 32'd0);
        check("w2_rd_data", rd, 32'hDEAD_BEEF);

        access(0, 1'b1, 10'h010, 32'h1122_3344, 4'b0101, lat, e, rd);
        access(0, 1'b0, 10'h010, 32'h0, 4'h0, lat, e, rd);
        check("be_rd_data", rd, 32'hDE22_BE44);

        access(0, 1'b1, 10'h010, 32'hFFFF_FFFF, 4'h0, lat, e, rd);
        check("be0_lat", 32'(lat), 32'd4);
        check("be0_err", 32'(e), 32'd0);
        access(0, 1'b0, 10'h010, 32'h0, 4'h0, lat, e, rd);
        check("be0_rd_data", rd, 32'hDE22_BE44);

        access(0, 1'b0, 10'h013, 32'h0, 4'h0, lat, e, rd);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(e), 32'd1);
        check("mis_rdata", rd, 32'h0);

        access(0, 1'b1, 10'h31C, 32'hCAFE_F00D, 4'hF, lat, e, rd);
        check("last_wr_err", 32'(e), 32'd0);
        access(0, 1'b0, 10'h31C, 32'h0, 4'h0, lat, e, rd);
        check("last_rd_data", rd, 32'hCAFE_F00D);
        access(0, 1'b1, 10'h320, 32'h1234_5678, 4'hF, lat, e, rd);
        check("oob_lat", 32'(lat), 32'd1);
        check("oob_err", 32'(e), 32'd1);
        check("oob_wr_rdata_hold", rd, 32'hCAFE_F00D);
        access(0, 1'b0, 10'h31C, 32'h0, 4'h0, lat, e, rd);
        check("oob_neighbor", rd, 32'hCAFE_F00D);
        check("err_clears", 32'(err[0]), 32'd0);

        access(1, 1'b1, 10'h020, 32'h55AA_55AA, 4'hF, lat, e, rd);
        check("w3_wr_lat", 32'(lat), 32'd5);
        we = 1'b1; addr = 10'h020; wdata = 32'h0BAD_F00D; be = 4'hF; req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        check("abort_busy", 32'(ready[1]), 32'd0);
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done[1]) dn++;
            step();
        end
        $display("inst1 abort: done pulses after reset = %0d", dn);
        check("abort_nodone", 32'(dn), 32'd0);
        check("abort_ready", 32'(ready[1]), 32'd1);
        access(1, 1'b0, 10'h020, 32'h0, 4'h0, lat, e, rd);
        check("abort_old_data", rd, 32'h55AA_55AA);

        access(2, 1'b1, 10'h040, 32'hA5A5_0F0F, 4'hF, lat, e, rd);
        check("w0_wr_lat", 32'(lat), 32'd2);
        we = 1'b0; addr = 10'h040; wdata = 32'h0; be = 4'h0; req[2] = 1'b1;
        acc = 0; dn = 0; run = 0; run_min = 99; run_max = 0;
        for (int i = 0; i < 12; i++) begin
            if (ready[2]) begin
                acc++;
                if (run > 0) begin
                    if (run < run_min) run_min = run;
                    if (run > run_max) run_max = run;
                end
                run = 0;
            end else begin
                run++;
            end
            if (done[2]) dn++;
            step();
        end
        req[2] = 1'b0;
        $display("inst2 b2b: accepts=%0d dones=%0d busy_run min=%0d max=%0d rdata=%h",
                 acc, dn, run_min, run_max, rdata[2]);
        check("b2b_accepts", 32'(acc), 32'd4);
        check("b2b_dones", 32'(dn), 32'd4);
        check("b2b_busy_min", 32'(run_min), 32'd2);
        check("b2b_busy_max", 32'(run_max), 32'd2);
        check("b2b_rdata", rdata[2], 32'hA5A5_0F0F);
        repeat (4) step();
        check("b2b_idle", 32'(ready[2]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
